// File: rtl/time_set_pkg.sv
// Shared definitions for the front-panel time-setting buttons: repeat FSM states
// and the default 100 MHz auto-repeat timing.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_SLOW_RPT  = 2'd2,
        ST_FAST_RPT  = 2'd3
    } state_e;

    localparam int unsigned DEF_HOLD_DELAY  = 50_000_000;
    localparam int unsigned DEF_SLOW_PERIOD = 10_000_000;
    localparam int unsigned DEF_FAST_PERIOD = 2_500_000;
    localparam int unsigned DEF_FAST_AFTER  = 8;
    localparam int unsigned DEF_CNT_W       = 26;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector on a synchronous level; the registered previous level
// resets to 0, so a level already high at reset release reads as a rise.
module edge_detect_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/button_repeat_ctrl.sv
// Turns a debounced button level into single-cycle step pulses: one on press,
// then auto-repeat at a slow rate that switches to a fast rate while held.
module button_repeat_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned HOLD_DELAY  = DEF_HOLD_DELAY,
    parameter int unsigned SLOW_PERIOD = DEF_SLOW_PERIOD,
    parameter int unsigned FAST_PERIOD = DEF_FAST_PERIOD,
    parameter int unsigned FAST_AFTER  = DEF_FAST_AFTER,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic Clk_100M,
    input  logic nReset,
    input  logic debounced,
    input  logic enable,
    output logic step,
    output logic held,
    output logic fast
);

    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(HOLD_DELAY - 1);
    localparam logic [CNT_W-1:0] SLOW_TERM = CNT_W'(SLOW_PERIOD - 1);
    localparam logic [CNT_W-1:0] FAST_TERM = CNT_W'(FAST_PERIOD - 1);
    localparam logic [7:0]       FAST_CNT  = 8'(FAST_AFTER);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rpt_q, rpt_d;
    logic             step_q, step_d;
    logic             held_q, fast_q;
    logic             rise;

    edge_detect_rise u_edge (
        .clk   (Clk_100M),
        .rst_n (nReset),
        .d     (debounced),
        .rise  (rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rpt_d   = rpt_q;
        step_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise && enable) begin
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    rpt_d   = '0;
                    state_d = ST_HOLD_WAIT;
                end
            end
            ST_HOLD_WAIT: begin
                if (cnt_q == HOLD_TERM) begin
                    step_d  = 1'b1;
                    cnt_d   = '0;
                    rpt_d   = 8'd1;
                    state_d = ST_SLOW_RPT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SLOW_RPT: begin
                // rpt_q already counts the first repeat, so the switch happens on
                // the FAST_AFTER-th step issued from the slow period.
                if (cnt_q == SLOW_TERM) begin
                    step_d = 1'b1;
                    cnt_d  = '0;
                    rpt_d  = (rpt_q == 8'hFF) ? rpt_q : rpt_q + 8'd1;
                    if (rpt_q == FAST_CNT) begin
                        state_d = ST_FAST_RPT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FAST_RPT: begin
                if (cnt_q == FAST_TERM) begin
                    step_d = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Release or disable overrides everything, including a terminal-count step.
        if (state_q != ST_IDLE && (!enable || !debounced)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rpt_d   = '0;
            step_d  = 1'b0;
        end
    end

    always_ff @(posedge Clk_100M or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rpt_q   <= '0;
            step_q  <= 1'b0;
            held_q  <= 1'b0;
            fast_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rpt_q   <= rpt_d;
            step_q  <= step_d;
            held_q  <= (state_d != ST_IDLE);
            fast_q  <= (state_d == ST_FAST_RPT);
        end
    end

    assign step = step_q & enable;
    assign held = held_q;
    assign fast = fast_q;

endmodule
